// File: rtl/aes_pkg.sv
// Shared AES byte-permutation helpers used by the ShiftRows datapath.
package aes_pkg;

  typedef logic [7:0] byte_t;

  // Left-rotation amount of row r. Wide blocks (Nb = 8) skip offset 2.
  function automatic int shift_offset(input int nb, input int r);
    return (nb == 8 && r >= 2) ? r + 1 : r;
  endfunction

  // Source byte index feeding output byte k for the forward permutation.
  function automatic int fwd_src_idx(input int nb, input int k);
    int r, c;
    r = k % 4;
    c = k / 4;
    return 4 * ((c + shift_offset(nb, r)) % nb) + r;
  endfunction

  // Source byte index feeding output byte k for the inverse permutation.
  function automatic int inv_src_idx(input int nb, input int k);
    int r, c;
    r = k % 4;
    c = k / 4;
    return 4 * ((c - shift_offset(nb, r) + nb) % nb) + r;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte router for an Nb-column state.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [0:32*NB-1] din,
  input  logic             inv,
  output logic [0:32*NB-1] dout
);

  // Each output byte is a fixed 2:1 choice between its forward and inverse source.
  for (genvar k = 0; k < 4 * NB; k++) begin : g_byte
    localparam int FS = fwd_src_idx(NB, k);
    localparam int IS = inv_src_idx(NB, k);
    byte_t fwd_b, inv_b;
    assign fwd_b = din[8*FS +: 8];
    assign inv_b = din[8*IS +: 8];
    assign dout[8*k +: 8] = inv ? inv_b : fwd_b;
  end

endmodule

// File: rtl/shift_rows_stream.sv
// Streaming ShiftRows engine: permutes on the way in, buffers results in a
// small circular FIFO behind valid/ready handshakes.
module shift_rows_stream
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [0:32*NB-1]         in_data,
  input  logic                     in_inv,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [0:32*NB-1]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int W  = 32 * NB;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_stream: NB must be 4, 6 or 8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("shift_rows_stream: DEPTH must be a power of two >= 2");
  end

  logic [0:W-1]     perm_data;
  logic [0:W-1]     mem_data [DEPTH];
  logic [TAG_W-1:0] mem_tag  [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             full, empty, push, pop;

  // Mode only steers the permutation; the FIFO stores finished blocks.
  shift_rows_perm #(.NB(NB)) u_perm (
    .din  (in_data),
    .inv  (in_inv),
    .dout (perm_data)
  );

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  // flush wins over both handshakes in the same cycle.
  assign push  = in_valid && !full && !flush;
  assign pop   = !empty && out_ready && !flush;

  // Pointer and occupancy state; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is left unreset; contents are only observed behind out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= perm_data;
      mem_tag[wr_ptr]  <= in_tag;
    end
  end

  // Handshake outputs come straight from registered state.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = mem_data[rd_ptr];
  assign out_tag   = mem_tag[rd_ptr];
  assign count     = cnt;

endmodule

// File: tb/tb_shift_rows_stream.sv
// Scoreboard bench for shift_rows_stream: an NB=4/DEPTH=2 instance and an
// NB=8/DEPTH=4 instance, checked against a row-rotation reference model.
module tb_shift_rows_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [0:255] d;
    logic [3:0]   tag;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  logic [3:0] popped4[$];
  int checks = 0;
  int errors = 0;

  // NB = 4, DEPTH = 2
  logic         v4 = 0, or4 = 0, inv4 = 0, fl4 = 0;
  logic [0:127] d4 = '0, od4;
  logic [3:0]   tg4 = '0, ot4;
  logic         rdy4, ov4;
  logic [1:0]   cnt4;

  // NB = 8, DEPTH = 4
  logic         v8 = 0, or8 = 0, inv8 = 0, fl8 = 0;
  logic [0:255] d8 = '0, od8;
  logic [3:0]   tg8 = '0, ot8;
  logic         rdy8, ov8;
  logic [2:0]   cnt8;

  shift_rows_stream #(.NB(4), .DEPTH(2), .TAG_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .flush(fl4), .in_valid(v4), .in_ready(rdy4),
    .in_data(d4), .in_inv(inv4), .in_tag(tg4), .out_valid(ov4), .out_ready(or4),
    .out_data(od4), .out_tag(ot4), .count(cnt4));

  shift_rows_stream #(.NB(8), .DEPTH(4), .TAG_W(4)) u8 (
    .clk(clk), .rst_n(rst_n), .flush(fl8), .in_valid(v8), .in_ready(rdy8),
    .in_data(d8), .in_inv(inv8), .in_tag(tg8), .out_valid(ov8), .out_ready(or8),
    .out_data(od8), .out_tag(ot8), .count(cnt8));

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: each state row is a list of bytes rotated left (forward) or
  // right (inverse) by the row's offset.
  function automatic logic [0:255] ref_perm(input int nb, input bit inv, input logic [0:255] d);
    logic [7:0]   row[$];
    logic [0:255] o;
    int           sh;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      row.delete();
      for (int c = 0; c < nb; c++) row.push_back(d[8*(4*c+r) +: 8]);
      sh = (nb == 8 && r > 1) ? r + 1 : r;
      repeat (sh) begin
        if (!inv) row.push_back(row.pop_front());
        else      row.push_front(row.pop_back());
      end
      for (int c = 0; c < nb; c++) o[8*(4*c+r) +: 8] = row[c];
    end
    return o;
  endfunction

  // Expected-response capture on every accepted block; flush discards.
  always @(negedge clk) begin : sb_push
    logic [0:255] p;
    if (rst_n) begin
      if (fl4) q4.delete();
      else if (v4 && rdy4) begin
        p = ref_perm(4, inv4, {d4, 128'b0});
        q4.push_back('{p, tg4});
      end
      if (fl8) q8.delete();
      else if (v8 && rdy8) begin
        p = ref_perm(8, inv8, d8);
        q8.push_back('{p, tg8});
      end
    end
  end

  always @(negedge rst_n) begin
    q4.delete();
    q8.delete();
  end

  // Monitor: compare the head whenever a pop handshake is about to complete.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && !fl4 && ov4 && or4) begin
      popped4.push_back(ot4);
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL u4_spurious: output tag %0d with nothing expected", ot4);
      end else begin
        e = q4.pop_front();
        chk("u4_data", {128'b0, od4}, {128'b0, e.d[0:127]});
        chk("u4_tag", {252'b0, ot4}, {252'b0, e.tag});
      end
    end
    if (rst_n && !fl8 && ov8 && or8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL u8_spurious: output tag %0d with nothing expected", ot8);
      end else begin
        e = q8.pop_front();
        chk("u8_data", od8, e.d);
        chk("u8_tag", {252'b0, ot8}, {252'b0, e.tag});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One directed NB=4 block: accept, check held output, then pop it.
  task automatic dir4(input string nm, input logic [0:127] d, input bit inv, input logic [0:127] exp);
    or4 = 0; v4 = 1; d4 = d; inv4 = inv; tg4 = 4'h5;
    step();
    v4 = 0;
    chk({nm, "_valid"}, {255'b0, ov4}, 256'd1);
    chk({nm, "_data"}, {128'b0, od4}, {128'b0, exp});
    or4 = 1;
    step();
    or4 = 0;
  endtask

  task automatic drain4(input string nm);
    int n = 0;
    or4 = 1; v4 = 0;
    while (cnt4 != 0 && n < 50) begin step(); n++; end
    chk({nm, "_drained"}, {254'b0, cnt4}, 256'd0);
  endtask

  task automatic drain8(input string nm);
    int n = 0;
    or8 = 1; v8 = 0;
    while (cnt8 != 0 && n < 50) begin step(); n++; end
    chk({nm, "_drained"}, {253'b0, cnt8}, 256'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [0:255] inc8, y8;
    logic [31:0]  col;
    bit           a;
    // reset state
    repeat (2) step();
    chk("rst_valid4", {255'b0, ov4}, 256'd0);
    chk("rst_ready4", {255'b0, rdy4}, 256'd1);
    chk("rst_count4", {254'b0, cnt4}, 256'd0);
    chk("rst_count8", {253'b0, cnt8}, 256'd0);
    rst_n = 1;
    step();

    // NB = 4 known vectors
    dir4("fwd_vec", 128'hd42711aee0bf98f1b8b45de51e415230, 1'b0,
         128'hd4bf5d30e0b452aeb84111f11e2798e5);
    dir4("inv_vec", 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1,
         128'hd42711aee0bf98f1b8b45de51e415230);
    dir4("inv_inc", 128'h000102030405060708090a0b0c0d0e0f, 1'b1,
         128'h000d0a0704010e0b0805020f0c090603);

    // NB = 8 forward then inverse round trip
    for (int k = 0; k < 32; k++) inc8[8*k +: 8] = 8'(k);
    or8 = 0; v8 = 1; d8 = inc8; inv8 = 0; tg8 = 4'h7;
    step();
    v8 = 0;
    chk("nb8_valid", {255'b0, ov8}, 256'd1);
    col = od8[0:31];
    chk("nb8_col0", {224'b0, col}, {224'b0, 32'h00050e13});
    col = od8[224:255];
    chk("nb8_col7", {224'b0, col}, {224'b0, 32'h1c010a0f});
    y8 = od8;
    or8 = 1; step(); or8 = 0;
    v8 = 1; d8 = y8; inv8 = 1; tg8 = 4'h8;
    step();
    v8 = 0;
    chk("nb8_roundtrip", od8, inc8);
    or8 = 1; step(); or8 = 0;

    // Backpressure on DEPTH = 2
    popped4.delete();
    or4 = 0; v4 = 1; inv4 = 0;
    d4 = {$urandom, $urandom, $urandom, $urandom}; tg4 = 4'd1; step();
    d4 = {$urandom, $urandom, $urandom, $urandom}; tg4 = 4'd2; step();
    d4 = {$urandom, $urandom, $urandom, $urandom}; tg4 = 4'd3; step();
    chk("bp_ready_low", {255'b0, rdy4}, 256'd0);
    chk("bp_count2", {254'b0, cnt4}, 256'd2);
    step();
    chk("bp_count_hold", {254'b0, cnt4}, 256'd2);
    or4 = 1;
    a = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = rdy4;
      @(posedge clk);
      #1;
      if (a) break;
    end
    v4 = 0;
    chk("bp_tag3_accepted", {255'b0, a}, 256'd1);
    drain4("bp");
    chk("bp_pop_count", 256'(popped4.size()), 256'd3);
    if (popped4.size() == 3) begin
      chk("bp_order0", {252'b0, popped4[0]}, 256'd1);
      chk("bp_order1", {252'b0, popped4[1]}, 256'd2);
      chk("bp_order2", {252'b0, popped4[2]}, 256'd3);
    end

    // Random traffic with stalls on both instances
    for (int i = 0; i < 60; i++) begin
      v4 = ($urandom % 4) != 0; or4 = ($urandom % 3) != 0; inv4 = $urandom % 2;
      d4 = {$urandom, $urandom, $urandom, $urandom}; tg4 = 4'($urandom);
      v8 = ($urandom % 4) != 0; or8 = ($urandom % 3) != 0; inv8 = $urandom % 2;
      for (int w = 0; w < 8; w++) d8[32*w +: 32] = $urandom;
      tg8 = 4'($urandom);
      step();
    end
    drain4("rnd4");
    drain8("rnd8");
    chk("rnd4_sb_empty", 256'(q4.size()), 256'd0);
    chk("rnd8_sb_empty", 256'(q8.size()), 256'd0);

    // Asynchronous reset with two blocks buffered
    or4 = 0; v4 = 1; tg4 = 4'd9; step(); step(); v4 = 0;
    chk("rst_pre_count", {254'b0, cnt4}, 256'd2);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", {255'b0, ov4}, 256'd0);
    chk("arst_count", {254'b0, cnt4}, 256'd0);
    chk("arst_ready", {255'b0, rdy4}, 256'd1);
    step();
    rst_n = 1;
    step();

    // flush with one block buffered and a push offered in the same cycle
    v4 = 1; tg4 = 4'd4; step(); v4 = 0;
    chk("fl_pre_count", {254'b0, cnt4}, 256'd1);
    fl4 = 1; v4 = 1; tg4 = 4'd6;
    step();
    fl4 = 0; v4 = 0;
    chk("fl_count", {254'b0, cnt4}, 256'd0);
    chk("fl_valid", {255'b0, ov4}, 256'd0);
    chk("fl_ready", {255'b0, rdy4}, 256'd1);
    step();
    chk("fl_count_after", {254'b0, cnt4}, 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
